decode_control_unit: RTL and testbench
======================================

# decode_control_unit

Decode/control stage that sits directly downstream of the fetch unit and drives its control inputs. Each cycle it registers the 9-bit instruction read from instruction memory at `instruction_number`, owns the `$branch` register, and resolves branches, jumps and halt. It produces the fetch unit's inputs: `branch_ctrl`, `jump_ctrl`, `jump_val`, `branch_val`, `init_ctrl` and `done_ctrl`. Non-control opcodes go to the ALU unchanged.

## Interface
Parameters:
- `INSTR_W`, default 9: instruction width (opcode `[8:5]`, imm5 `[4:0]`).
- `PC_W`, default 8: width of `jump_val` and `branch_val`.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `instr_in`  in  9  instruction word at the current `instruction_number`.
- `zero_flag`  in  1  ALU zero result; sampled during a BZ/BNZ decode.
- `init_ctrl`  out  1  PC-to-zero request to the fetch unit.
- `branch_ctrl`  out  1  relative-branch request.
- `jump_ctrl`  out  1  absolute-jump request.
- `done_ctrl`  out  1  halt indication.
- `jump_val`  out  8  absolute target.
- `branch_val`  out  8  signed PC offset (`$branch`).
- `alu_op`  out  4  opcode forwarded to the ALU.
- `alu_imm`  out  5  immediate forwarded to the ALU.
- `alu_valid`  out  1  forwarded op is live.
- `branch_count`  out  16  taken branch/jump count; exists only with `DECODE_BRANCH_STATS_EN`.

## Operation
Opcodes:
- 0x0 NOP.
- 0x1 SETB: `$branch <= sign-extend(imm5)` to 8 bits.
- 0x2 BZ: taken when `zero_flag` = 1.
- 0x3 BNZ: taken when `zero_flag` = 0.
- 0x4 JMP: target = `{imm5, 3'b000}`.
- 0xF HALT.
- 0x5–0xE: ALU ops, forwarded as `alu_op`/`alu_imm` with `alu_valid` = 1.

FSM states:
- INIT: entered on reset. Drives `init_ctrl` = 1 and all other outputs 0. Moves to RUN after 1 cycle.
- RUN: `ir <= instr_in` every cycle; decodes `ir`.
  - Taken BZ/BNZ: `branch_ctrl` = 1.
  - JMP: `jump_ctrl` = 1.
  - Either case moves to SQUASH.
  - HALT moves to DONE.
- SQUASH: `ir <= NOP` and `instr_in` is discarded, removing exactly 1 wrong-path slot. All control outputs are 0. Returns to RUN.
- DONE: `done_ctrl` = 1, held permanently. `ir` is frozen. Only reset exits.

Boundary rules:
- Control outputs are decoded combinationally from `ir` and state, and are stable before the falling edge, where the fetch unit samples them.
- At most one of `branch_ctrl`, `jump_ctrl`, `init_ctrl` is 1 in any cycle.
- `branch_val` always equals `$branch`. Branch arithmetic is 8-bit two's complement and wraps in the fetch unit (PC 0x02 + 0xF0 gives 0xF2). The block performs no range check.
- SETB immediately followed by a branch: the branch uses the new `$branch` value, because the update lands before the branch reaches `ir`.
- A branch or jump that is itself in the squashed slot is never executed.
- Reset is sampled every edge. Asserting it mid-SQUASH or in DONE returns to INIT on the next edge.

Reset values:
- `ir` = NOP; `$branch` = 0x00; `branch_count` = 0.
- All outputs 0 except `init_ctrl`, which is 1 while `reset_n` = 0 and during the INIT cycle.

## Timing
- Latency from instruction presented to control output: 1 cycle (`ir` register).
- Taken branch or jump costs 2 cycles: the decode cycle plus 1 squash cycle.
- HALT: `done_ctrl` rises in the cycle HALT sits in `ir` and stays high.
- `zero_flag` must be valid in the same cycle the branch occupies `ir`.

## Configuration
- `DECODE_BRANCH_STATS_EN` defined:
  - `branch_count` increments by 1 on every taken branch or jump.
  - It saturates at 0xFFFF and resets to 0.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package `decode_pkg` holds:
  - opcode constants (`OP_NOP`, `OP_SETB`, `OP_BZ`, `OP_BNZ`, `OP_JMP`, `OP_HALT`);
  - the state enum (INIT, RUN, SQUASH, DONE);
  - `NOP_WORD`.
- Sub-module `opcode_decoder`: combinational; maps `ir` plus `zero_flag` to `is_setb`, `take_branch`, `is_jump`, `is_halt`, `is_alu`.

## Test plan
- Reset released: exactly 1 INIT cycle with `init_ctrl` = 1, then RUN; `branch_val` = 0x00, all other controls 0.
- SETB 0x1C (−4) then BNZ with `zero_flag` = 0: `branch_val` = 0xFC and `branch_ctrl` = 1 for 1 cycle. The next `instr_in` (ALU op 0x5) is squashed, so `alu_valid` stays 0 that cycle.
- BZ with `zero_flag` = 0: no control pulse, no squash; the following ALU op 0x6 gives `alu_valid` = 1 and `alu_op` = 0x6.
- JMP imm5 = 0x03: `jump_ctrl` = 1, `jump_val` = 0x18; the next instruction is squashed.
- HALT: `done_ctrl` = 1 that cycle and held; later JMP words on `instr_in` produce no `jump_ctrl`. Pulling `reset_n` low returns the block to INIT.
- With `DECODE_BRANCH_STATS_EN`: 3 taken branches plus 1 untaken give `branch_count` = 3. Preloading the counter to 0xFFFF and taking another branch leaves it at 0xFFFF.

Source files
------------

// File: rtl/decode_control_unit_pkg.sv
// Shared decode definitions: opcode constants, control FSM state encoding, NOP word.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package decode_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_SETB = 4'h1;
  localparam logic [3:0] OP_BZ   = 4'h2;
  localparam logic [3:0] OP_BNZ  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [8:0] NOP_WORD = {OP_NOP, 5'h00};

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/decode_control_unit_opcode_decoder.sv
// Opcode classifier: turns the registered opcode plus the ALU zero flag into decode strobes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; strobes are qualified by the control FSM in the parent.
// Ports: op_i (opcode field of ir), zero_flag_i -> is_setb_o, take_branch_o,
//        is_jump_o, is_halt_o, is_alu_o.
module opcode_decoder
  import decode_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       zero_flag_i,
  output logic       is_setb_o,
  output logic       take_branch_o,
  output logic       is_jump_o,
  output logic       is_halt_o,
  output logic       is_alu_o
);

  always_comb begin
    is_setb_o     = 1'b0;
    take_branch_o = 1'b0;
    is_jump_o     = 1'b0;
    is_halt_o     = 1'b0;
    is_alu_o      = 1'b0;
    case (op_i)
      OP_NOP:  ;
      OP_SETB: is_setb_o     = 1'b1;
      OP_BZ:   take_branch_o = zero_flag_i;
      OP_BNZ:  take_branch_o = ~zero_flag_i;
      OP_JMP:  is_jump_o     = 1'b1;
      OP_HALT: is_halt_o     = 1'b1;
      default: is_alu_o      = 1'b1;  // 0x5..0xE
    endcase
  end

endmodule

// File: rtl/decode_control_unit.sv
// Decode/control stage: registers the fetched instruction, owns $branch, resolves branch/jump/halt.
// Latency: 1 cycle from instr_in to control outputs (ir register); taken branch/jump adds 1 squash cycle.
// Backpressure: none; a taken branch/jump discards one wrong-path slot, HALT freezes until reset.
// Ports: clock, reset_n (sync, active-low), instr_in, zero_flag ->
//        init_ctrl, branch_ctrl, jump_ctrl, done_ctrl, jump_val, branch_val,
//        alu_op, alu_imm, alu_valid, branch_count (only with DECODE_BRANCH_STATS_EN).
// Optional feature macro: DECODE_BRANCH_STATS_EN adds a saturating taken-branch/jump counter.
module decode_control_unit
  import decode_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int PC_W    = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               zero_flag,
  output logic               init_ctrl,
  output logic               branch_ctrl,
  output logic               jump_ctrl,
  output logic               done_ctrl,
  output logic [PC_W-1:0]    jump_val,
  output logic [PC_W-1:0]    branch_val,
  output logic [3:0]         alu_op,
  output logic [4:0]         alu_imm,
  output logic               alu_valid
`ifdef DECODE_BRANCH_STATS_EN
  ,
  output logic [15:0]        branch_count
`endif
);

  localparam logic [INSTR_W-1:0] NOP_IR = INSTR_W'(NOP_WORD);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    branch_q, branch_d;

  logic [3:0] ir_op;
  logic [4:0] ir_imm;
  assign ir_op  = ir_q[INSTR_W-1 -: 4];
  assign ir_imm = ir_q[4:0];

  logic is_setb, take_branch, is_jump, is_halt, is_alu;

  opcode_decoder u_dec (
    .op_i          (ir_op),
    .zero_flag_i   (zero_flag),
    .is_setb_o     (is_setb),
    .take_branch_o (take_branch),
    .is_jump_o     (is_jump),
    .is_halt_o     (is_halt),
    .is_alu_o      (is_alu)
  );

  // Unqualified (pre-reset-gating) output values from the FSM.
  logic            init_c, branch_c, jump_c, done_c, alu_valid_c;
  logic [PC_W-1:0] jump_val_c;
  logic [3:0]      alu_op_c;
  logic [4:0]      alu_imm_c;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    branch_d    = branch_q;
    init_c      = 1'b0;
    branch_c    = 1'b0;
    jump_c      = 1'b0;
    done_c      = 1'b0;
    alu_valid_c = 1'b0;
    jump_val_c  = '0;
    alu_op_c    = '0;
    alu_imm_c   = '0;
    case (state_q)
      INIT: begin
        init_c  = 1'b1;
        ir_d    = NOP_IR;
        state_d = RUN;
      end
      RUN: begin
        ir_d = instr_in;
        // SETB lands at this edge, so a branch entering ir next cycle already sees it.
        if (is_setb) branch_d = {{(PC_W-5){ir_imm[4]}}, ir_imm};
        if (take_branch) begin
          branch_c = 1'b1;
          state_d  = SQUASH;
        end else if (is_jump) begin
          jump_c     = 1'b1;
          jump_val_c = PC_W'({ir_imm, 3'b000});
          state_d    = SQUASH;
        end else if (is_halt) begin
          done_c  = 1'b1;
          ir_d    = ir_q;  // keep HALT in ir; DONE freezes it there
          state_d = DONE;
        end else if (is_alu) begin
          alu_valid_c = 1'b1;
          alu_op_c    = ir_op;
          alu_imm_c   = ir_imm;
        end
      end
      SQUASH: begin
        // The word in ir is the wrong-path slot: every strobe stays low, nothing executes.
        ir_d    = NOP_IR;
        state_d = RUN;
      end
      DONE: begin
        done_c = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= INIT;
      ir_q     <= NOP_IR;
      branch_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      branch_q <= branch_d;
    end
  end

  // While reset_n is low the fetch unit must see a PC-to-zero request immediately,
  // even before the reset edge has moved the FSM back to INIT.
  assign init_ctrl   = ~reset_n | init_c;
  assign branch_ctrl = reset_n & branch_c;
  assign jump_ctrl   = reset_n & jump_c;
  assign done_ctrl   = reset_n & done_c;
  assign alu_valid   = reset_n & alu_valid_c;
  assign jump_val    = reset_n ? jump_val_c : '0;
  assign alu_op      = reset_n ? alu_op_c   : '0;
  assign alu_imm     = reset_n ? alu_imm_c  : '0;
  assign branch_val  = branch_q;

`ifdef DECODE_BRANCH_STATS_EN
  logic [15:0] branch_count_q, branch_count_d;

  always_comb begin
    branch_count_d = branch_count_q;
    if ((branch_c || jump_c) && (branch_count_q != 16'hFFFF))
      branch_count_d = branch_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) branch_count_q <= '0;
    else          branch_count_q <= branch_count_d;
  end

  assign branch_count = branch_count_q;
`endif

endmodule

// File: tb/tb_decode_control_unit.sv
// Directed bench for decode_control_unit: reset/INIT, SETB+branch, untaken branch,
// jump with squash, back-to-back SETB/branch, HALT and reset recovery.
// Optional counter scenarios are compiled with DECODE_BRANCH_STATS_EN.
module tb_decode_control_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [8:0] instr_in;
  logic       zero_flag;
  logic       init_ctrl, branch_ctrl, jump_ctrl, done_ctrl, alu_valid;
  logic [7:0] jump_val, branch_val;
  logic [3:0] alu_op;
  logic [4:0] alu_imm;
`ifdef DECODE_BRANCH_STATS_EN
  logic [15:0] branch_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  decode_control_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_in    (instr_in),
    .zero_flag   (zero_flag),
    .init_ctrl   (init_ctrl),
    .branch_ctrl (branch_ctrl),
    .jump_ctrl   (jump_ctrl),
    .done_ctrl   (done_ctrl),
    .jump_val    (jump_val),
    .branch_val  (branch_val),
    .alu_op      (alu_op),
    .alu_imm     (alu_imm),
    .alu_valid   (alu_valid)
`ifdef DECODE_BRANCH_STATS_EN
    ,
    .branch_count(branch_count)
`endif
  );

  localparam logic [8:0] W_NOP    = 9'h000;
  localparam logic [8:0] W_SETB_M4 = 9'h03C;  // SETB imm 0x1C (-4)
  localparam logic [8:0] W_SETB_5 = 9'h025;   // SETB imm 0x05
  localparam logic [8:0] W_BZ     = 9'h040;
  localparam logic [8:0] W_BNZ    = 9'h060;
  localparam logic [8:0] W_JMP3   = 9'h083;
  localparam logic [8:0] W_JMP5   = 9'h085;
  localparam logic [8:0] W_ALU5   = 9'h0A0;
  localparam logic [8:0] W_ALU6   = 9'h0CA;   // op 6, imm 0x0A
  localparam logic [8:0] W_ALU8   = 9'h103;   // op 8, imm 0x03
  localparam logic [8:0] W_ALU9   = 9'h121;
  localparam logic [8:0] W_HALT   = 9'h1E0;

  // Advance one clock; the word driven here sits in ir during the next cycle.
  task automatic tick(input logic [8:0] w, input logic z);
    @(posedge clock);
    #1;
    instr_in  = w;
    zero_flag = z;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; instr_in = W_NOP; zero_flag = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total_cnt++; if (init_ctrl !== 1'b1) $display("FAIL rst_init got %b exp 1", init_ctrl); else pass_cnt++;
    total_cnt++; if (branch_val !== 8'h00) $display("FAIL rst_bval got %h exp 00", branch_val); else pass_cnt++;
    reset_n = 1'b1;
    #1;
    total_cnt++; if (init_ctrl !== 1'b1) $display("FAIL init_cycle got %b exp 1", init_ctrl); else pass_cnt++;
    total_cnt++; if ({branch_ctrl, jump_ctrl, done_ctrl, alu_valid} !== 4'b0000)
      $display("FAIL init_others got %b exp 0000", {branch_ctrl, jump_ctrl, done_ctrl, alu_valid}); else pass_cnt++;
    tick(W_NOP, 1'b0);
    total_cnt++; if (init_ctrl !== 1'b0) $display("FAIL run_init got %b exp 0", init_ctrl); else pass_cnt++;
    total_cnt++; if ({branch_ctrl, jump_ctrl, done_ctrl, alu_valid} !== 4'b0000)
      $display("FAIL run_others got %b exp 0000", {branch_ctrl, jump_ctrl, done_ctrl, alu_valid}); else pass_cnt++;
    total_cnt++; if (branch_val !== 8'h00) $display("FAIL run_bval got %h exp 00", branch_val); else pass_cnt++;
  endtask

  task automatic test_setb_bnz();
    tick(W_SETB_M4, 1'b0);
    tick(W_BNZ, 1'b0);
    tick(W_ALU5, 1'b0);  // ir = BNZ, zero_flag = 0 -> taken
    total_cnt++; if (branch_ctrl !== 1'b1) $display("FAIL bnz_taken got %b exp 1", branch_ctrl); else pass_cnt++;
    total_cnt++; if (branch_val !== 8'hFC) $display("FAIL bnz_bval got %h exp fc", branch_val); else pass_cnt++;
    total_cnt++; if ({jump_ctrl, init_ctrl} !== 2'b00) $display("FAIL bnz_excl got %b exp 00", {jump_ctrl, init_ctrl}); else pass_cnt++;
    tick(W_NOP, 1'b0);   // squash cycle, ir = ALU5 wrong path
    total_cnt++; if (alu_valid !== 1'b0) $display("FAIL bnz_squash_alu got %b exp 0", alu_valid); else pass_cnt++;
    total_cnt++; if (branch_ctrl !== 1'b0) $display("FAIL bnz_pulse_len got %b exp 0", branch_ctrl); else pass_cnt++;
    tick(W_ALU8, 1'b0);
    tick(W_NOP, 1'b0);   // ir = ALU8
    total_cnt++; if ({alu_valid, alu_op, alu_imm} !== {1'b1, 4'h8, 5'h03})
      $display("FAIL post_squash_alu got %b_%h_%h exp 1_8_03", alu_valid, alu_op, alu_imm); else pass_cnt++;
  endtask

  task automatic test_bz();
    tick(W_BZ, 1'b0);
    tick(W_ALU6, 1'b0);  // ir = BZ, zero_flag = 0 -> not taken
    total_cnt++; if (branch_ctrl !== 1'b0) $display("FAIL bz_untaken got %b exp 0", branch_ctrl); else pass_cnt++;
    tick(W_NOP, 1'b0);   // ir = ALU6, no squash
    total_cnt++; if ({alu_valid, alu_op, alu_imm} !== {1'b1, 4'h6, 5'h0A})
      $display("FAIL bz_next_alu got %b_%h_%h exp 1_6_0a", alu_valid, alu_op, alu_imm); else pass_cnt++;
    tick(W_BZ, 1'b0);
    tick(W_NOP, 1'b1);   // ir = BZ, zero_flag = 1 -> taken
    total_cnt++; if (branch_ctrl !== 1'b1) $display("FAIL bz_taken got %b exp 1", branch_ctrl); else pass_cnt++;
    tick(W_NOP, 1'b1);
    tick(W_NOP, 1'b0);
  endtask

  task automatic test_jmp();
    tick(W_JMP3, 1'b0);
    tick(W_ALU9, 1'b0);  // ir = JMP 3
    total_cnt++; if (jump_ctrl !== 1'b1) $display("FAIL jmp_ctrl got %b exp 1", jump_ctrl); else pass_cnt++;
    total_cnt++; if (jump_val !== 8'h18) $display("FAIL jmp_val got %h exp 18", jump_val); else pass_cnt++;
    total_cnt++; if (branch_ctrl !== 1'b0) $display("FAIL jmp_excl got %b exp 0", branch_ctrl); else pass_cnt++;
    tick(W_NOP, 1'b0);   // squash, ir = ALU9
    total_cnt++; if ({alu_valid, jump_ctrl} !== 2'b00) $display("FAIL jmp_squash got %b exp 00", {alu_valid, jump_ctrl}); else pass_cnt++;
    // A jump sitting in the squashed slot must not fire.
    tick(W_JMP3, 1'b0);
    tick(W_JMP5, 1'b0);
    tick(W_NOP, 1'b0);   // squash, ir = JMP5
    total_cnt++; if ({jump_ctrl, jump_val} !== 9'h000) $display("FAIL squashed_jmp got %b_%h exp 0_00", jump_ctrl, jump_val); else pass_cnt++;
    tick(W_NOP, 1'b0);
    total_cnt++; if (jump_ctrl !== 1'b0) $display("FAIL squashed_jmp_late got %b exp 0", jump_ctrl); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    tick(W_SETB_5, 1'b0);
    tick(W_BZ, 1'b0);
    tick(W_NOP, 1'b1);   // ir = BZ right behind SETB
    total_cnt++; if ({branch_ctrl, branch_val} !== {1'b1, 8'h05})
      $display("FAIL b2b_branch got %b_%h exp 1_05", branch_ctrl, branch_val); else pass_cnt++;
    tick(W_NOP, 1'b0);
    tick(W_NOP, 1'b0);
  endtask

  task automatic test_halt();
    tick(W_HALT, 1'b0);
    tick(W_JMP3, 1'b0);  // ir = HALT
    total_cnt++; if ({done_ctrl, jump_ctrl} !== 2'b10) $display("FAIL halt_first got %b exp 10", {done_ctrl, jump_ctrl}); else pass_cnt++;
    tick(W_JMP3, 1'b0);
    total_cnt++; if ({done_ctrl, jump_ctrl, alu_valid} !== 3'b100) $display("FAIL halt_hold got %b exp 100", {done_ctrl, jump_ctrl, alu_valid}); else pass_cnt++;
    tick(W_JMP5, 1'b0);
    total_cnt++; if ({done_ctrl, jump_ctrl} !== 2'b10) $display("FAIL halt_hold2 got %b exp 10", {done_ctrl, jump_ctrl}); else pass_cnt++;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    total_cnt++; if ({init_ctrl, done_ctrl} !== 2'b10) $display("FAIL halt_rst_comb got %b exp 10", {init_ctrl, done_ctrl}); else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++; if ({init_ctrl, done_ctrl, branch_val} !== {2'b10, 8'h00})
      $display("FAIL halt_rst_edge got %b_%h exp 10_00", {init_ctrl, done_ctrl}, branch_val); else pass_cnt++;
    reset_n = 1'b1; instr_in = W_NOP;
    #1;
    total_cnt++; if (init_ctrl !== 1'b1) $display("FAIL rerun_init got %b exp 1", init_ctrl); else pass_cnt++;
    tick(W_NOP, 1'b0);
    total_cnt++; if ({init_ctrl, done_ctrl} !== 2'b00) $display("FAIL rerun_run got %b exp 00", {init_ctrl, done_ctrl}); else pass_cnt++;
  endtask

`ifdef DECODE_BRANCH_STATS_EN
  task automatic test_branch_stats();
    tick(W_JMP3, 1'b0); tick(W_NOP, 1'b0); tick(W_NOP, 1'b0);
    tick(W_BZ, 1'b0);   tick(W_NOP, 1'b1); tick(W_NOP, 1'b0);
    tick(W_BNZ, 1'b0);  tick(W_NOP, 1'b0); tick(W_NOP, 1'b0);
    tick(W_BZ, 1'b0);   tick(W_NOP, 1'b0); tick(W_NOP, 1'b0);
    total_cnt++; if (branch_count !== 16'd3) $display("FAIL stats_count got %h exp 0003", branch_count); else pass_cnt++;
    dut.branch_count_q = 16'hFFFF;
    tick(W_JMP3, 1'b0); tick(W_NOP, 1'b0); tick(W_NOP, 1'b0);
    total_cnt++; if (branch_count !== 16'hFFFF) $display("FAIL stats_sat got %h exp ffff", branch_count); else pass_cnt++;
  endtask
`endif

  initial begin
    reset_n = 1'b0; instr_in = W_NOP; zero_flag = 1'b0;
    test_reset();
    test_setb_bnz();
    test_bz();
    test_jmp();
    test_back_to_back();
    test_halt();
`ifdef DECODE_BRANCH_STATS_EN
    test_branch_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
